write_back_buffer: RTL and testbench
====================================

WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16: line size in bytes; OFFSET_BITS = CLOG2(LINE_SIZE), LA_BITS = 32 - OFFSET_BITS.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffered evicted lines, a power of 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 wb_valid  input  1  cache enqueues a dirty evicted line.
REQ-007 wb_line_addr  input  LA_BITS  line address (byte address >> OFFSET_BITS) of evicted line.
REQ-008 wb_data  input  LINE_SIZE*8  evicted line data.
REQ-009 wb_ready  output  1  enqueue accepted this cycle.
REQ-010 rd_valid_in  input  1  cache line-fill read request.
REQ-011 rd_line_addr  input  LA_BITS  line address to fill.
REQ-012 rd_ready  output  1  read request accepted this cycle.
REQ-013 rd_valid  output  1  fill data valid (one-cycle pulse).
REQ-014 rd_data  output  LINE_SIZE*8  fill data.
REQ-015 rd_fwd  output  1  qualifies rd_valid: data forwarded from buffer.
REQ-016 mem_is_input_valid, mem_read, mem_write  output  1 each  request to line memory.
REQ-017 mem_addr  output  LA_BITS; mem_din  output  LINE_SIZE*8  request address / write data.
REQ-018 mem_ready  input  1; mem_is_output_valid  input  1; mem_dout  input  LINE_SIZE*8  memory handshake and read data.

Function
REQ-019 Buffer SHALL be a circular FIFO of DEPTH entries {valid, line_addr, data} with head/tail pointers and a count 0..DEPTH.
REQ-020 wb_ready SHALL be 1 when count < DEPTH or when wb_line_addr matches a valid entry not issued this cycle.
REQ-021 Enqueue to a line already buffered SHALL overwrite that entry's data in place (coalesce), with count unchanged.
REQ-022 Enqueue to a new line SHALL write at tail; tail wraps DEPTH-1 -> 0; count +1.
REQ-023 FSM states: IDLE, RD_WAIT.
REQ-024 IDLE: rd_ready = 1; an accepted read whose line matches a buffered entry or a same-cycle enqueue SHALL drive rd_valid = rd_fwd = 1 the next cycle with that data (same-cycle enqueue data has precedence); no memory access.
REQ-025 IDLE: an accepted read that misses SHALL issue mem_read when mem_ready = 1 (held until accepted) and go to RD_WAIT; rd_ready = 0 until return.
REQ-026 RD_WAIT: on mem_is_output_valid, rd_data = mem_dout, rd_valid = 1, rd_fwd = 0 in that same cycle; return to IDLE.
REQ-027 Drain: in IDLE with no read pending, count > 0 and mem_ready = 1, SHALL issue mem_write of the head entry; entry freed and head advanced (wrapping) in that cycle.
REQ-028 Reads SHALL have priority over drains; if count == DEPTH, drain SHALL have priority over a new missing read.
REQ-029 Enqueue and drain in the same cycle SHALL leave count unchanged; a coalesce to the head entry being drained SHALL instead allocate a new tail entry.
REQ-030 At most one memory request SHALL be outstanding; mem_is_input_valid is 1 only for the cycle of issue.
REQ-031 Enqueue when full with no coalesce match SHALL be ignored (wb_ready = 0) with no state change.

Reset
REQ-032 On reset: count = 0, head = tail = 0, all entries invalid, FSM = IDLE.
REQ-033 Reset values: wb_ready = 1, rd_ready = 1, rd_valid = 0, rd_fwd = 0, rd_data = 0, all mem_* outputs = 0.
REQ-034 Reset mid-operation SHALL discard buffered lines and any in-flight read; a late mem_is_output_valid after reset SHALL be ignored.

Structure
REQ-035 OFFSET_BITS/LA_BITS derivation and FSM state encodings SHALL live in the shared package alongside the cache constants, using the CLOG2 macro.
REQ-036 One sub-module SHALL be used: wbb_match, a combinational DEPTH-way address comparator returning hit and entry index.

Verification
REQ-037 Enqueue 0x100 data A, read 0x100 -> rd_valid/rd_fwd next cycle, rd_data = A, no mem_read.
REQ-038 Enqueue 0x100 A then 0x100 B -> count 1; drain writes B to mem_addr 0x100.
REQ-039 Fill DEPTH=4 lines, enqueue 5th new line -> wb_ready = 0; after one drain -> wb_ready = 1, tail wraps to 0.
REQ-040 Read 0x200 miss, memory returns C after 5 cycles -> one mem_read, rd_valid with C, rd_fwd = 0, no drain while RD_WAIT.
REQ-041 Same-cycle enqueue 0x300 D and read 0x300 -> rd_data = D next cycle.
REQ-042 Reset asserted in RD_WAIT with 2 buffered lines -> count 0, IDLE, later mem_is_output_valid produces no rd_valid.

Source files
------------

// File: rtl/write_back_buffer_pkg.sv
// Shared constants, address-width derivation and FSM encoding for the write-back buffer.
// Pure declarations: no logic, no state.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package write_back_buffer_pkg;

    localparam int WBB_ADDR_BITS      = 32;
    localparam int WBB_LINE_SIZE_DEF  = 16;
    localparam int WBB_DEPTH_DEF      = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } wbb_state_e;

    function automatic int wbb_offset_bits(input int line_size);
        return `CLOG2(line_size);
    endfunction

endpackage

// File: rtl/write_back_buffer_match.sv
// DEPTH-way line-address comparator over the buffer entries; purely combinational.
// Returns the lowest matching valid entry; entries never hold duplicate lines.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module wbb_match #(
    parameter int  DEPTH   = 4,
    parameter int  LA_BITS = 28,
    localparam int IDX_W   = `CLOG2(DEPTH)
) (
    input  logic [DEPTH-1:0]              ent_vld,
    input  logic [DEPTH-1:0][LA_BITS-1:0] ent_addr,
    input  logic [LA_BITS-1:0]            key,
    output logic                          hit,
    output logic [IDX_W-1:0]              idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && ent_vld[i] && ent_addr[i] == key) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// Coalescing FIFO of evicted dirty lines, drained to memory; services fills by forwarding (1 cycle) or memory.
// wb_ready drops only when full without a coalesce hit; rd_ready drops while a memory read is pending.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module write_back_buffer
    import write_back_buffer_pkg::*;
#(
    parameter int  LINE_SIZE   = WBB_LINE_SIZE_DEF,
    parameter int  DEPTH       = WBB_DEPTH_DEF,
    localparam int OFFSET_BITS = wbb_offset_bits(LINE_SIZE),
    localparam int LA_BITS     = WBB_ADDR_BITS - OFFSET_BITS,
    localparam int DW          = LINE_SIZE * 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [LA_BITS-1:0] wb_line_addr,
    input  logic [DW-1:0]      wb_data,
    output logic               wb_ready,
    input  logic               rd_valid_in,
    input  logic [LA_BITS-1:0] rd_line_addr,
    output logic               rd_ready,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               rd_fwd,
    output logic               mem_is_input_valid,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LA_BITS-1:0] mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic               mem_ready,
    input  logic               mem_is_output_valid,
    input  logic [DW-1:0]      mem_dout
);

    localparam int PTR_W = `CLOG2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0][LA_BITS-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0]      data_q, data_d;
    logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    wbb_state_e                    state_q, state_d;
    logic                          pend_q, pend_d;
    logic [LA_BITS-1:0]            pend_addr_q, pend_addr_d;
    logic                          fwd_vld_q, fwd_vld_d;
    logic [DW-1:0]                 fwd_dat_q, fwd_dat_d;

    logic             wb_hit, rd_hit_buf;
    logic [PTR_W-1:0] wb_idx, rd_idx;
    logic             full, wb_acc, rd_acc, rd_same, rd_hit, miss_new, read_req;
    logic             issue_read, issue_drain, ret, coal, alloc;
    logic [LA_BITS-1:0] read_addr;

    wbb_match #(.DEPTH(DEPTH), .LA_BITS(LA_BITS)) u_wb_match (
        .ent_vld  (vld_q),
        .ent_addr (addr_q),
        .key      (wb_line_addr),
        .hit      (wb_hit),
        .idx      (wb_idx)
    );

    wbb_match #(.DEPTH(DEPTH), .LA_BITS(LA_BITS)) u_rd_match (
        .ent_vld  (vld_q),
        .ent_addr (addr_q),
        .key      (rd_line_addr),
        .hit      (rd_hit_buf),
        .idx      (rd_idx)
    );

    // A hit on the head being drained still reports ready: the drain frees a slot for the re-allocation.
    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        wb_ready    = !full || wb_hit;
        wb_acc      = wb_valid && wb_ready;
        rd_ready    = (state_q == IDLE) && !pend_q;
        rd_acc      = rd_valid_in && rd_ready;
        rd_same     = wb_acc && (wb_line_addr == rd_line_addr);
        rd_hit      = rd_same || rd_hit_buf;
        miss_new    = rd_acc && !rd_hit;
        read_req    = miss_new || pend_q;
        read_addr   = pend_q ? pend_addr_q : rd_line_addr;
        issue_drain = !reset && (state_q == IDLE) && mem_ready && (count_q != '0) && (!read_req || full);
        issue_read  = !reset && (state_q == IDLE) && mem_ready && read_req && !issue_drain;
        ret         = !reset && (state_q == RD_WAIT) && mem_is_output_valid;
        coal        = wb_acc && wb_hit && !(issue_drain && (wb_idx == head_q));
        alloc       = wb_acc && !coal;
    end

    // Free the drained head before allocating, so a full-buffer reuse of that slot keeps it valid.
    always_comb begin
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (issue_drain) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (coal) begin
            data_d[wb_idx] = wb_data;
        end
        if (alloc) begin
            vld_d[tail_q]  = 1'b1;
            addr_d[tail_q] = wb_line_addr;
            data_d[tail_q] = wb_data;
            tail_d         = tail_q + PTR_W'(1);
        end
        case ({alloc, issue_drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        fwd_vld_d   = rd_acc && rd_hit;
        fwd_dat_d   = fwd_dat_q;
        if (rd_acc && rd_hit) begin
            fwd_dat_d = rd_same ? wb_data : data_q[rd_idx];
        end
        case (state_q)
            IDLE: begin
                if (issue_read) begin
                    state_d = RD_WAIT;
                    pend_d  = 1'b0;
                end else if (miss_new) begin
                    pend_d      = 1'b1;
                    pend_addr_d = rd_line_addr;
                end
            end
            RD_WAIT: begin
                if (ret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            fwd_vld_q   <= 1'b0;
            fwd_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            fwd_vld_q   <= fwd_vld_d;
            fwd_dat_q   <= fwd_dat_d;
        end
    end

    assign rd_valid           = fwd_vld_q || ret;
    assign rd_fwd             = fwd_vld_q;
    assign rd_data            = ret ? mem_dout : (fwd_vld_q ? fwd_dat_q : '0);
    assign mem_is_input_valid = issue_read || issue_drain;
    assign mem_read           = issue_read;
    assign mem_write          = issue_drain;
    assign mem_addr           = issue_read ? read_addr : (issue_drain ? addr_q[head_q] : '0);
    assign mem_din            = issue_drain ? data_q[head_q] : '0;

endmodule

// File: tb/tb_write_back_buffer.sv
// Scenario bench for write_back_buffer: fills and memory writes are scored against queued expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_write_back_buffer;

    localparam int LA = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [LA-1:0] wb_line_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;
    logic          rd_valid_in;
    logic [LA-1:0] rd_line_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_fwd;
    logic          mem_is_input_valid;
    logic          mem_read;
    logic          mem_write;
    logic [LA-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_ready;
    logic          mem_is_output_valid;
    logic [DW-1:0] mem_dout;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fwd;
    } rd_exp_t;

    typedef struct packed {
        logic [LA-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    rd_exp_t exp_rd_q[$];
    wr_exp_t exp_wr_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      n_mem_rd = 0;

    always #5 clk = ~clk;

    write_back_buffer dut (
        .clk                 (clk),
        .reset               (reset),
        .wb_valid            (wb_valid),
        .wb_line_addr        (wb_line_addr),
        .wb_data             (wb_data),
        .wb_ready            (wb_ready),
        .rd_valid_in         (rd_valid_in),
        .rd_line_addr        (rd_line_addr),
        .rd_ready            (rd_ready),
        .rd_valid            (rd_valid),
        .rd_data             (rd_data),
        .rd_fwd              (rd_fwd),
        .mem_is_input_valid  (mem_is_input_valid),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_addr            (mem_addr),
        .mem_din             (mem_din),
        .mem_ready           (mem_ready),
        .mem_is_output_valid (mem_is_output_valid),
        .mem_dout            (mem_dout)
    );

    function automatic logic [DW-1:0] dat(input int s);
        return {4{32'hC0DE_0000 | 32'(s)}};
    endfunction

    // One clock: score outputs on the falling edge, return just after the next rising edge.
    task automatic cycle();
        rd_exp_t er;
        wr_exp_t ew;
        @(negedge clk);
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                $display("FAIL rd_out: got rd_valid=1 data=%h fwd=%b, expected no fill", rd_data, rd_fwd);
            end else begin
                er = exp_rd_q.pop_front();
                if (rd_data !== er.data || rd_fwd !== er.fwd)
                    $display("FAIL rd_out: got data=%h fwd=%b, expected data=%h fwd=%b", rd_data, rd_fwd, er.data, er.fwd);
                else
                    n_pass++;
            end
        end
        if (mem_is_input_valid === 1'b1 && mem_write === 1'b1) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL mem_wr: got write addr=%h data=%h, expected no write", mem_addr, mem_din);
            end else begin
                ew = exp_wr_q.pop_front();
                if (mem_addr !== ew.addr || mem_din !== ew.data)
                    $display("FAIL mem_wr: got addr=%h data=%h, expected addr=%h data=%h", mem_addr, mem_din, ew.addr, ew.data);
                else
                    n_pass++;
            end
        end
        if (mem_is_input_valid === 1'b1 && mem_read === 1'b1) n_mem_rd++;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input logic [LA-1:0] a, input logic [DW-1:0] d);
        wb_valid     = 1'b1;
        wb_line_addr = a;
        wb_data      = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        n_checks++; if (wb_ready !== 1'b1) $display("FAIL reset_wb_ready: got %b expected 1", wb_ready); else n_pass++;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL reset_rd_ready: got %b expected 1", rd_ready); else n_pass++;
        n_checks++; if ({rd_valid, rd_fwd} !== 2'b00) $display("FAIL reset_rd_flags: got %b expected 00", {rd_valid, rd_fwd}); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", rd_data); else n_pass++;
        n_checks++;
        if ({mem_is_input_valid, mem_read, mem_write} !== 3'b000 || mem_addr !== '0 || mem_din !== '0)
            $display("FAIL reset_mem: got vld/rd/wr=%b addr=%h din=%h expected all 0", {mem_is_input_valid, mem_read, mem_write}, mem_addr, mem_din);
        else n_pass++;
        cycle();
    endtask

    task automatic test_fwd_hit();
        int rd0 = n_mem_rd;
        mem_ready = 1'b0;
        wb_drive(28'h100, dat(1));
        cycle();
        wb_valid     = 1'b0;
        rd_valid_in  = 1'b1;
        rd_line_addr = 28'h100;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL hit_rd_ready: got %b expected 1", rd_ready); else n_pass++;
        exp_rd_q.push_back(rd_exp_t'{dat(1), 1'b1});
        cycle();
        rd_valid_in = 1'b0;
        cycle();
        n_checks++; if (n_mem_rd != rd0) $display("FAIL hit_no_mem_read: got %0d reads expected 0", n_mem_rd - rd0); else n_pass++;
        mem_ready = 1'b1;
        exp_wr_q.push_back(wr_exp_t'{28'h100, dat(1)});
        cycle();
        cycle();
    endtask

    task automatic test_coalesce();
        mem_ready = 1'b0;
        wb_drive(28'h100, dat(2));
        cycle();
        wb_drive(28'h100, dat(3));
        #1;
        n_checks++; if (wb_ready !== 1'b1) $display("FAIL coal_wb_ready: got %b expected 1", wb_ready); else n_pass++;
        cycle();
        wb_valid  = 1'b0;
        mem_ready = 1'b1;
        exp_wr_q.push_back(wr_exp_t'{28'h100, dat(3)});
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_full_wrap();
        int rd0;
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_drive(28'h1000 + LA'(i), dat(10 + i));
            #1;
            n_checks++; if (wb_ready !== 1'b1) $display("FAIL full_fill%0d: got wb_ready=%b expected 1", i, wb_ready); else n_pass++;
            cycle();
        end
        wb_drive(28'h1004, dat(14));
        #1;
        n_checks++; if (wb_ready !== 1'b0) $display("FAIL full_reject: got wb_ready=%b expected 0", wb_ready); else n_pass++;
        cycle();
        wb_valid     = 1'b0;
        rd0          = n_mem_rd;
        rd_valid_in  = 1'b1;
        rd_line_addr = 28'h700;
        mem_ready    = 1'b1;
        #1;
        n_checks++;
        if ({mem_write, mem_read} !== 2'b10) $display("FAIL full_drain_first: got wr/rd=%b expected 10", {mem_write, mem_read}); else n_pass++;
        exp_wr_q.push_back(wr_exp_t'{28'h1000, dat(10)});
        cycle();
        rd_valid_in = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h700) $display("FAIL full_read_second: got rd=%b addr=%h expected 1 000700", mem_read, mem_addr); else n_pass++;
        cycle();
        mem_ready           = 1'b0;
        mem_is_output_valid = 1'b1;
        mem_dout            = dat(77);
        exp_rd_q.push_back(rd_exp_t'{dat(77), 1'b0});
        cycle();
        mem_is_output_valid = 1'b0;
        n_checks++; if (n_mem_rd - rd0 != 1) $display("FAIL full_read_count: got %0d expected 1", n_mem_rd - rd0); else n_pass++;
        wb_drive(28'h1004, dat(14));
        #1;
        n_checks++; if (wb_ready !== 1'b1) $display("FAIL wrap_accept: got wb_ready=%b expected 1", wb_ready); else n_pass++;
        cycle();
        wb_drive(28'h1002, dat(99));
        #1;
        n_checks++; if (wb_ready !== 1'b1) $display("FAIL full_coalesce: got wb_ready=%b expected 1", wb_ready); else n_pass++;
        cycle();
        wb_valid = 1'b0;
        exp_wr_q.push_back(wr_exp_t'{28'h1001, dat(11)});
        exp_wr_q.push_back(wr_exp_t'{28'h1002, dat(99)});
        exp_wr_q.push_back(wr_exp_t'{28'h1003, dat(13)});
        exp_wr_q.push_back(wr_exp_t'{28'h1004, dat(14)});
        mem_ready = 1'b1;
        repeat (5) cycle();
    endtask

    task automatic test_read_miss();
        int rd0;
        mem_ready = 1'b0;
        wb_drive(28'h50, dat(5));
        cycle();
        wb_valid     = 1'b0;
        rd0          = n_mem_rd;
        rd_valid_in  = 1'b1;
        rd_line_addr = 28'h200;
        mem_ready    = 1'b1;
        #1;
        n_checks++;
        if ({mem_is_input_valid, mem_read, mem_write} !== 3'b110) $display("FAIL miss_issue: got vld/rd/wr=%b expected 110", {mem_is_input_valid, mem_read, mem_write}); else n_pass++;
        n_checks++; if (mem_addr !== 28'h200) $display("FAIL miss_addr: got %h expected 0000200", mem_addr); else n_pass++;
        cycle();
        rd_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (rd_ready !== 1'b0 || mem_is_input_valid !== 1'b0)
                $display("FAIL miss_wait%0d: got rd_ready=%b mem_vld=%b expected 0 0", i, rd_ready, mem_is_input_valid);
            else n_pass++;
            cycle();
        end
        mem_is_output_valid = 1'b1;
        mem_dout            = dat(12);
        exp_rd_q.push_back(rd_exp_t'{dat(12), 1'b0});
        cycle();
        mem_is_output_valid = 1'b0;
        exp_wr_q.push_back(wr_exp_t'{28'h50, dat(5)});
        cycle();
        cycle();
        n_checks++; if (n_mem_rd - rd0 != 1) $display("FAIL miss_read_count: got %0d expected 1", n_mem_rd - rd0); else n_pass++;
    endtask

    task automatic test_same_cycle();
        mem_ready = 1'b0;
        wb_drive(28'h300, dat(30));
        cycle();
        wb_drive(28'h300, dat(31));
        rd_valid_in  = 1'b1;
        rd_line_addr = 28'h300;
        exp_rd_q.push_back(rd_exp_t'{dat(31), 1'b1});
        cycle();
        wb_valid    = 1'b0;
        rd_valid_in = 1'b0;
        cycle();
        mem_ready = 1'b1;
        exp_wr_q.push_back(wr_exp_t'{28'h300, dat(31)});
        cycle();
        cycle();
    endtask

    task automatic test_reset_rd_wait();
        mem_ready = 1'b0;
        wb_drive(28'h500, dat(50));
        cycle();
        wb_drive(28'h501, dat(51));
        cycle();
        wb_valid     = 1'b0;
        rd_valid_in  = 1'b1;
        rd_line_addr = 28'h400;
        mem_ready    = 1'b1;
        cycle();
        rd_valid_in = 1'b0;
        reset       = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_checks++; if (rd_ready !== 1'b1) $display("FAIL rst_wait_rd_ready: got %b expected 1", rd_ready); else n_pass++;
        n_checks++; if (mem_is_input_valid !== 1'b0) $display("FAIL rst_wait_no_drain: got mem_vld=%b expected 0", mem_is_input_valid); else n_pass++;
        cycle();
        cycle();
        mem_is_output_valid = 1'b1;
        mem_dout            = dat(66);
        #1;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_late_return: got rd_valid=%b expected 0", rd_valid); else n_pass++;
        cycle();
        mem_is_output_valid = 1'b0;
        mem_ready           = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_drive(28'h600 + LA'(i), dat(60 + i));
            #1;
            n_checks++;
            if (wb_ready !== (i < 4)) $display("FAIL rst_refill%0d: got wb_ready=%b expected %b", i, wb_ready, (i < 4)); else n_pass++;
            cycle();
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_wr_q.push_back(wr_exp_t'{28'h600 + LA'(i), dat(60 + i)});
        mem_ready = 1'b1;
        repeat (5) cycle();
    endtask

    task automatic test_end();
        n_checks++; if (exp_rd_q.size() != 0) $display("FAIL end_rd_pending: got %0d fills outstanding expected 0", exp_rd_q.size()); else n_pass++;
        n_checks++; if (exp_wr_q.size() != 0) $display("FAIL end_wr_pending: got %0d writes outstanding expected 0", exp_wr_q.size()); else n_pass++;
    endtask

    initial begin
        reset               = 1'b1;
        wb_valid            = 1'b0;
        wb_line_addr        = '0;
        wb_data             = '0;
        rd_valid_in         = 1'b0;
        rd_line_addr        = '0;
        mem_ready           = 1'b0;
        mem_is_output_valid = 1'b0;
        mem_dout            = '0;
        test_reset();
        test_fwd_hit();
        test_coalesce();
        test_full_wrap();
        test_read_miss();
        test_same_cycle();
        test_reset_rd_wait();
        test_end();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
